// File: rtl/commit_stage_if.sv
//------------------------------------------------------------------------------
// commit_stage_if : scoreboard-to-commit handshake, regfile write and exception bus
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface commit_stage_if #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned REG_ADDR_W      = 5,
  parameter int unsigned XLEN            = 64
);
  logic                                       halt_i;
  logic [NR_COMMIT_PORTS-1:0]                 commit_valid_i;
  logic [NR_COMMIT_PORTS-1:0][REG_ADDR_W-1:0] commit_rd_i;
  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]       commit_result_i;
  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]       commit_pc_i;
  logic [NR_COMMIT_PORTS-1:0]                 commit_ex_valid_i;
  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]       commit_ex_cause_i;
  logic [NR_COMMIT_PORTS-1:0]                 commit_is_store_i;
  logic [NR_COMMIT_PORTS-1:0]                 commit_ack_o;
  logic [NR_COMMIT_PORTS-1:0][REG_ADDR_W-1:0] waddr_o;
  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]       wdata_o;
  logic [NR_COMMIT_PORTS-1:0]                 we_o;
  logic                                       commit_lsu_o;
  logic                                       commit_lsu_ready_i;
  logic                                       ex_valid_o;
  logic [XLEN-1:0]                            ex_cause_o;
  logic [XLEN-1:0]                            ex_pc_o;
  logic                                       flush_o;
  logic [63:0]                                instret_o;

  modport master (
    output halt_i, commit_valid_i, commit_rd_i, commit_result_i, commit_pc_i,
           commit_ex_valid_i, commit_ex_cause_i, commit_is_store_i, commit_lsu_ready_i,
    input  commit_ack_o, waddr_o, wdata_o, we_o, commit_lsu_o,
           ex_valid_o, ex_cause_o, ex_pc_o, flush_o, instret_o
  );

  modport slave (
    input  halt_i, commit_valid_i, commit_rd_i, commit_result_i, commit_pc_i,
           commit_ex_valid_i, commit_ex_cause_i, commit_is_store_i, commit_lsu_ready_i,
    output commit_ack_o, waddr_o, wdata_o, we_o, commit_lsu_o,
           ex_valid_o, ex_cause_o, ex_pc_o, flush_o, instret_o
  );
endinterface

`default_nettype wire

// File: rtl/commit_stage.sv
//------------------------------------------------------------------------------
// commit_stage : in-order retirement of the two oldest scoreboard entries
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module commit_stage #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned REG_ADDR_W      = 5,
  parameter int unsigned XLEN            = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  commit_stage_if.slave bus
);

  if (NR_COMMIT_PORTS != 2) begin : g_bad_nr_ports
    $error("commit_stage: only NR_COMMIT_PORTS = 2 is supported");
  end

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e          r_state;
  logic            r_ex_valid;
  logic            r_flush;
  logic [XLEN-1:0] r_ex_cause;
  logic [XLEN-1:0] r_ex_pc;
  logic [63:0]     r_instret;

  logic            w_run;
  logic            w_p0_ok;
  logic            w_lsu_req;
  logic [1:0]      w_ack;
  logic [1:0]      w_we;
  logic            w_take_ex;
  logic [63:0]     w_retired;

  always_comb begin
    w_run     = rst_ni && (r_state == ST_RUN) && !bus.halt_i;
    w_p0_ok   = w_run && bus.commit_valid_i[0];
    w_lsu_req = w_p0_ok && !bus.commit_ex_valid_i[0] && bus.commit_is_store_i[0];

    w_ack[0]  = w_p0_ok && (bus.commit_ex_valid_i[0] || !bus.commit_is_store_i[0]
                            || bus.commit_lsu_ready_i);
    // Port 1 only retires behind a plain ALU op on port 0; stores and
    // exceptions on port 1 wait until they become the oldest entry.
    w_ack[1]  = w_ack[0] && !bus.commit_ex_valid_i[0] && !bus.commit_is_store_i[0]
                && bus.commit_valid_i[1] && !bus.commit_ex_valid_i[1]
                && !bus.commit_is_store_i[1];

    w_we[1]   = w_ack[1] && !bus.commit_ex_valid_i[1] && (bus.commit_rd_i[1] != '0);
    // Same destination on both ports: only the younger write survives.
    w_we[0]   = w_ack[0] && !bus.commit_ex_valid_i[0] && (bus.commit_rd_i[0] != '0)
                && !(w_we[1] && (bus.commit_rd_i[0] == bus.commit_rd_i[1]));

    w_take_ex = w_ack[0] && bus.commit_ex_valid_i[0];
    w_retired = 64'(w_ack[0]) + 64'(w_ack[1]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_RUN;
      r_ex_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_ex_cause <= '0;
      r_ex_pc    <= '0;
      r_instret  <= '0;
    end else begin
      r_instret  <= r_instret + w_retired;
      r_ex_valid <= w_take_ex;
      r_flush    <= w_take_ex;
      if (w_take_ex) begin
        r_ex_cause <= bus.commit_ex_cause_i[0];
        r_ex_pc    <= bus.commit_pc_i[0];
      end
      case (r_state)
        ST_RUN:   if (w_take_ex) r_state <= ST_FLUSH;
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.commit_ack_o = w_ack;
  assign bus.we_o         = w_we;
  assign bus.waddr_o      = bus.commit_rd_i;
  assign bus.wdata_o      = bus.commit_result_i;
  assign bus.commit_lsu_o = w_lsu_req;
  assign bus.ex_valid_o   = r_ex_valid;
  assign bus.flush_o      = r_flush;
  assign bus.ex_cause_o   = r_ex_cause;
  assign bus.ex_pc_o      = r_ex_pc;
  assign bus.instret_o    = r_instret;

  a_ack_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((w_ack & ~bus.commit_valid_i) == 2'b00));

  a_ack1_needs_ack0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_ack[1] |-> w_ack[0]));

endmodule

`default_nettype wire

// File: tb/tb_commit_stage.sv
//------------------------------------------------------------------------------
// tb_commit_stage : directed checks of retirement, stores, exceptions, halt, reset
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_commit_stage;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  commit_stage_if bus ();

  commit_stage u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.halt_i             = 1'b0;
    bus.commit_valid_i     = '0;
    bus.commit_rd_i        = '0;
    bus.commit_result_i    = '0;
    bus.commit_pc_i        = '0;
    bus.commit_ex_valid_i  = '0;
    bus.commit_ex_cause_i  = '0;
    bus.commit_is_store_i  = '0;
    bus.commit_lsu_ready_i = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [4:0] rd, input logic [63:0] res,
                          input logic ex, input logic [63:0] cause,
                          input logic [63:0] pc, input logic st);
    bus.commit_valid_i[p]    = 1'b1;
    bus.commit_rd_i[p]       = rd;
    bus.commit_result_i[p]   = res;
    bus.commit_ex_valid_i[p] = ex;
    bus.commit_ex_cause_i[p] = cause;
    bus.commit_pc_i[p]       = pc;
    bus.commit_is_store_i[p] = st;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    clear_inputs();
    #2;
    chk("rst_ack",      64'(bus.commit_ack_o), 64'd0);
    chk("rst_we",       64'(bus.we_o),         64'd0);
    chk("rst_lsu",      64'(bus.commit_lsu_o), 64'd0);
    chk("rst_ex_valid", 64'(bus.ex_valid_o),   64'd0);
    chk("rst_flush",    64'(bus.flush_o),      64'd0);
    chk("rst_instret",  bus.instret_o,         64'd0);
    chk("rst_cause",    bus.ex_cause_o,        64'd0);
    chk("rst_pc",       bus.ex_pc_o,           64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two independent ALU results
    set_port(0, 5'd3, 64'hA, 1'b0, 64'd0, 64'h1000, 1'b0);
    set_port(1, 5'd4, 64'hB, 1'b0, 64'd0, 64'h1004, 1'b0);
    #1;
    chk("t1_ack",    64'(bus.commit_ack_o), 64'b11);
    chk("t1_we",     64'(bus.we_o),         64'b11);
    chk("t1_waddr0", 64'(bus.waddr_o[0]),   64'd3);
    chk("t1_waddr1", 64'(bus.waddr_o[1]),   64'd4);
    chk("t1_wdata0", bus.wdata_o[0],        64'hA);
    chk("t1_wdata1", bus.wdata_o[1],        64'hB);
    chk("t1_inst0",  bus.instret_o,         64'd0);
    tick();
    chk("t1_inst2",  bus.instret_o,         64'd2);

    // Same destination on both ports
    set_port(0, 5'd5, 64'h55, 1'b0, 64'd0, 64'h1008, 1'b0);
    set_port(1, 5'd5, 64'h66, 1'b0, 64'd0, 64'h100C, 1'b0);
    #1;
    chk("t2_ack",    64'(bus.commit_ack_o), 64'b11);
    chk("t2_we",     64'(bus.we_o),         64'b10);
    chk("t2_wdata1", bus.wdata_o[1],        64'h66);
    tick();
    chk("t2_inst",   bus.instret_o,         64'd4);

    // Store stalled by the LSU for three cycles
    clear_inputs();
    set_port(0, 5'd0, 64'd0, 1'b0, 64'd0, 64'h1010, 1'b1);
    set_port(1, 5'd6, 64'h77, 1'b0, 64'd0, 64'h1014, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_lsu_wait", 64'(bus.commit_lsu_o), 64'd1);
      chk("t3_ack_wait", 64'(bus.commit_ack_o), 64'b00);
      tick();
    end
    chk("t3_inst_stall", bus.instret_o, 64'd4);
    bus.commit_lsu_ready_i = 1'b1;
    #1;
    chk("t3_lsu_go", 64'(bus.commit_lsu_o), 64'd1);
    chk("t3_ack_go", 64'(bus.commit_ack_o), 64'b01);
    chk("t3_we_go",  64'(bus.we_o),         64'b00);
    tick();
    chk("t3_inst",   bus.instret_o,         64'd5);

    // Exception on port 0
    clear_inputs();
    set_port(0, 5'd7, 64'h99, 1'b1, 64'd2, 64'h80000010, 1'b0);
    set_port(1, 5'd3, 64'h1,  1'b0, 64'd0, 64'h80000014, 1'b0);
    #1;
    chk("t4_ack",   64'(bus.commit_ack_o), 64'b01);
    chk("t4_we",    64'(bus.we_o),         64'b00);
    chk("t4_lsu",   64'(bus.commit_lsu_o), 64'd0);
    chk("t4_flush_early", 64'(bus.flush_o), 64'd0);
    tick();
    chk("t4_ex_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("t4_flush",    64'(bus.flush_o),    64'd1);
    chk("t4_cause",    bus.ex_cause_o,      64'd2);
    chk("t4_pc",       bus.ex_pc_o,         64'h80000010);
    chk("t4_inst",     bus.instret_o,       64'd6);
    clear_inputs();
    set_port(0, 5'd3, 64'h1, 1'b0, 64'd0, 64'h2000, 1'b0);
    set_port(1, 5'd4, 64'h2, 1'b0, 64'd0, 64'h2004, 1'b0);
    #1;
    chk("t4_ack_flush", 64'(bus.commit_ack_o), 64'b00);
    chk("t4_we_flush",  64'(bus.we_o),         64'b00);
    tick();
    chk("t4_ex_valid_end", 64'(bus.ex_valid_o),   64'd0);
    chk("t4_flush_end",    64'(bus.flush_o),      64'd0);
    chk("t4_ack_resume",   64'(bus.commit_ack_o), 64'b11);
    tick();
    chk("t4_inst_resume",  bus.instret_o,         64'd8);

    // Halt blocks ordinary retirement and exceptions alike
    bus.halt_i = 1'b1;
    #1;
    chk("t5_ack_halt", 64'(bus.commit_ack_o), 64'b00);
    tick();
    chk("t5_inst_halt", bus.instret_o, 64'd8);
    clear_inputs();
    bus.halt_i = 1'b1;
    set_port(0, 5'd9, 64'h0, 1'b1, 64'd4, 64'h3000, 1'b0);
    #1;
    chk("t5_ack_halt_ex", 64'(bus.commit_ack_o), 64'b00);
    tick();
    chk("t5_flush_halt_ex", 64'(bus.flush_o), 64'd0);
    chk("t5_inst_halt_ex",  bus.instret_o,    64'd8);
    clear_inputs();
    set_port(0, 5'd0, 64'h5, 1'b0, 64'd0, 64'h3004, 1'b0);
    #1;
    chk("t5_ack_x0", 64'(bus.commit_ack_o), 64'b01);
    chk("t5_we_x0",  64'(bus.we_o),         64'b00);
    tick();
    chk("t5_inst_x0", bus.instret_o, 64'd9);

    // Exception on port 1 waits behind an ALU op on port 0
    clear_inputs();
    set_port(0, 5'd1, 64'h11, 1'b0, 64'd0, 64'h3008, 1'b0);
    set_port(1, 5'd2, 64'h22, 1'b1, 64'd7, 64'h300C, 1'b0);
    #1;
    chk("t5_ack_p1ex", 64'(bus.commit_ack_o), 64'b01);
    chk("t5_we_p1ex",  64'(bus.we_o),         64'b01);
    tick();
    chk("t5_flush_p1ex", 64'(bus.flush_o), 64'd0);
    chk("t5_inst_p1ex",  bus.instret_o,    64'd10);

    // Asynchronous reset while flushing
    clear_inputs();
    set_port(0, 5'd8, 64'h0, 1'b1, 64'd5, 64'h100, 1'b0);
    tick();
    chk("t6_flush_pre", 64'(bus.flush_o), 64'd1);
    clear_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_flush_rst",    64'(bus.flush_o),    64'd0);
    chk("t6_ex_valid_rst", 64'(bus.ex_valid_o), 64'd0);
    chk("t6_inst_rst",     bus.instret_o,       64'd0);
    chk("t6_cause_rst",    bus.ex_cause_o,      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_port(0, 5'd3, 64'h1, 1'b0, 64'd0, 64'h4000, 1'b0);
    set_port(1, 5'd4, 64'h2, 1'b0, 64'd0, 64'h4004, 1'b0);
    #1;
    chk("t6_ack_run", 64'(bus.commit_ack_o), 64'b11);
    tick();
    chk("t6_inst_run",  bus.instret_o,    64'd2);
    chk("t6_flush_run", 64'(bus.flush_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
